// File: rtl/aes_round_engine.sv
// Iterative AES encryptor: one shared round datapath split into SUB and MIX phases, NR = 10/12/14.
// Optional macro AES_ENGINE_OVERLAP_EN lets a new block be accepted in the same cycle as the output handshake.
module aes_round_engine #(
  parameter int NR       = 10,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_block,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_block,
  output logic                busy
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_engine: NR must be 10, 12 or 14");
  end
  if ((1 << RK_IDX_W) <= NR) begin : g_bad_idx_w
    $error("aes_round_engine: RK_IDX_W too narrow to hold NR");
  end

  localparam logic [RK_IDX_W-1:0] NR_IDX = RK_IDX_W'(NR);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [RK_IDX_W-1:0]   r_rcnt;
  logic [127:0]          r_st;
  logic [127:0]          r_st_t;
  logic [127:0]          r_out_block;
  logic [127:0]          w_sr;
  logic [127:0]          w_mc;
  logic                  w_load;
  logic                  w_sub;
  logic                  w_round;
  logic                  w_final;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i sits at row i%4, column i/4; ShiftRows pulls from column (c + r) mod 4.
  for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
    localparam int SRC = (gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4);
    assign w_sr[127-8*gi -: 8] = SBOX[r_st[127-8*SRC -: 8]];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = r_st_t[127-32*gi -: 8];
    assign w_a1 = r_st_t[119-32*gi -: 8];
    assign w_a2 = r_st_t[111-32*gi -: 8];
    assign w_a3 = r_st_t[103-32*gi -: 8];
    assign w_mc[127-32*gi -: 32] = {
      xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
      w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3,
      w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3,
      xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3)
    };
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    rk_idx       = '0;
    w_load       = 1'b0;
    w_sub        = 1'b0;
    w_round      = 1'b0;
    w_final      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load       = 1'b1;
          w_state_next = SUB;
        end
      end
      SUB: begin
        rk_idx       = r_rcnt;
        w_sub        = 1'b1;
        w_state_next = MIX;
      end
      MIX: begin
        rk_idx = r_rcnt;
        if (r_rcnt == NR_IDX) begin
          w_final      = 1'b1;
          w_state_next = DONE;
        end else begin
          w_round      = 1'b1;
          w_state_next = SUB;
        end
      end
      DONE: begin
`ifdef AES_ENGINE_OVERLAP_EN
        // rk_idx stays 0 here so a block taken on the handshake gets its whitening key.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_load       = 1'b1;
            w_state_next = SUB;
          end else begin
            w_state_next = IDLE;
          end
        end
`else
        if (out_ready) w_state_next = IDLE;
`endif
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rcnt      <= '0;
      r_st        <= '0;
      r_st_t      <= '0;
      r_out_block <= '0;
    end else begin
      if (w_load) begin
        r_st   <= in_block ^ rk;
        r_rcnt <= RK_IDX_W'(1);
      end
      if (w_sub) r_st_t <= w_sr;
      if (w_round) begin
        r_st   <= w_mc ^ rk;
        r_rcnt <= r_rcnt + 1'b1;
      end
      if (w_final) r_out_block <= r_st_t ^ rk;
    end
  end

  assign out_valid = (r_state == DONE);
  assign out_block = r_out_block;
  assign busy      = (r_state != IDLE);

endmodule
